// File: rtl/button_conditioner.sv
// ------------------------------------------------------------------------------
// button_conditioner: per-channel sync, majority debounce, release/lockout, auto-repeat
// Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
  parameter int                NUM_CH        = 4,
  parameter int                WINDOW        = 700,
  parameter int                THRESH        = 500,
  parameter int                RELEASE       = 64,
  parameter int                LOCKOUT       = 4500000,
  parameter int                REPEAT_DELAY  = 25000000,
  parameter int                REPEAT_PERIOD = 5000000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW    = NUM_CH'(1)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] press_level,
  output logic              any_press
);

  localparam int WIN_W     = $clog2(WINDOW + 1);
  localparam int REL_W     = $clog2(RELEASE + 1);
  localparam int LOCK_W    = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam int LOCK_LAST = (LOCKOUT > 0) ? LOCKOUT - 1 : 0;
  localparam int HOLD_W    = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int PER_W     = $clog2(REPEAT_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HELD   = 2'd2,
    LOCK   = 2'd3
  } state_t;

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] act;

  // Sync flops reset to each pin's inactive level so act starts at 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign act = sync2_q ^ ACTIVE_LOW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W-1:0]  hit_q, hit_d;
    logic [WIN_W-1:0]  hit_next;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic              pulse_q, pulse_d;
    logic              level_q, level_d;
    logic              rpt_due;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state_q <= IDLE;
        win_q   <= '0;
        hit_q   <= '0;
        rel_q   <= '0;
        lock_q  <= '0;
        hold_q  <= '0;
        per_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        win_q   <= win_d;
        hit_q   <= hit_d;
        rel_q   <= rel_d;
        lock_q  <= lock_d;
        hold_q  <= hold_d;
        per_q   <= per_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      hit_d    = hit_q;
      rel_d    = rel_q;
      lock_d   = lock_q;
      hold_d   = hold_q;
      per_d    = per_q;
      pulse_d  = 1'b0;
      level_d  = level_q;
      rpt_due  = 1'b0;
      hit_next = hit_q + WIN_W'(act[i]);
      unique case (state_q)
        IDLE: begin
          if (act[i]) begin
            state_d = SAMPLE;
            win_d   = WIN_W'(1);
            hit_d   = WIN_W'(1);
          end
        end
        SAMPLE: begin
          win_d = win_q + WIN_W'(1);
          hit_d = hit_next;
          // This cycle's sample is the last one of the window.
          if (win_q == WIN_W'(WINDOW - 1)) begin
            win_d = '0;
            hit_d = '0;
            if (hit_next >= WIN_W'(THRESH)) begin
              state_d = HELD;
              pulse_d = 1'b1;
              level_d = 1'b1;
              rel_d   = '0;
              hold_d  = '0;
              per_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (!repeat_en[i]) begin
            hold_d = '0;
            per_d  = '0;
          end else if (hold_q != HOLD_W'(REPEAT_DELAY)) begin
            hold_d  = hold_q + HOLD_W'(1);
            rpt_due = (hold_d == HOLD_W'(REPEAT_DELAY));
          end else if (per_q == PER_W'(REPEAT_PERIOD - 1)) begin
            per_d   = '0;
            rpt_due = 1'b1;
          end else begin
            per_d = per_q + PER_W'(1);
          end
          if (act[i]) begin
            rel_d = '0;
          end else if (rel_q == REL_W'(RELEASE - 1)) begin
            // Release takes priority over a repeat falling on the same cycle.
            rel_d   = '0;
            level_d = 1'b0;
            rpt_due = 1'b0;
            hold_d  = '0;
            per_d   = '0;
            lock_d  = '0;
            state_d = (LOCKOUT == 0) ? IDLE : LOCK;
          end else begin
            rel_d = rel_q + REL_W'(1);
          end
          pulse_d = rpt_due;
        end
        LOCK: begin
          if (lock_q == LOCK_W'(LOCK_LAST)) begin
            lock_d  = '0;
            state_d = IDLE;
          end else begin
            lock_d = lock_q + LOCK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign press_pulse[i] = pulse_q;
    assign press_level[i] = level_q;
  end

  assign any_press = |press_pulse;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ------------------------------------------------------------------------------
// tb_button_conditioner: directed checks of debounce, lockout, repeat and reset
// Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] raw_in;
  logic [3:0] repeat_en;
  logic [3:0] press_pulse;
  logic [3:0] press_level;
  logic       any_press;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;

  // History indexed by negedges since the last mark(); index k is sampled k negedges after the drive.
  logic [3:0] pulse_h [0:79];
  logic [3:0] level_h [0:79];
  logic       any_h   [0:79];

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_CH        (4),
    .WINDOW        (8),
    .THRESH        (6),
    .RELEASE       (4),
    .LOCKOUT       (10),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5),
    .ACTIVE_LOW    (4'b0001)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .raw_in      (raw_in),
    .repeat_en   (repeat_en),
    .press_pulse (press_pulse),
    .press_level (press_level),
    .any_press   (any_press)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    t = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (t < 79) t++;
      pulse_h[t] = press_pulse;
      level_h[t] = press_level;
      any_h[t]   = any_press;
    end
  endtask

  function automatic int npulse(input int ch, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(pulse_h[k][ch]);
    return c;
  endfunction

  initial begin
    resetN    = 1'b0;
    raw_in    = 4'b0001;
    repeat_en = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_pulse", press_pulse, 4'b0000);
    check("reset_level", press_level, 4'b0000);
    check("reset_any",   any_press,   1'b0);
    resetN = 1'b1;
    run(3);

    // Clean active-high press on ch1, released after 30 cycles.
    mark(); raw_in[1] = 1'b1; run(30); raw_in[1] = 1'b0; run(20);
    check("t1_pulse_pre",  pulse_h[9],  4'b0000);
    check("t1_pulse",      pulse_h[10], 4'b0010);
    check("t1_any",        any_h[10],   1'b1);
    check("t1_pulse_post", pulse_h[11], 4'b0000);
    check("t1_count",      npulse(1, 1, 50), 1);
    check("t1_level_on",   level_h[10][1], 1'b1);
    check("t1_level_hold", level_h[35][1], 1'b1);
    check("t1_level_off",  level_h[36][1], 1'b0);

    // Bounce 1,0,1,0,... gives 4 hits in the window: rejected.
    mark();
    for (int k = 0; k < 8; k++) begin
      raw_in[1] = (k % 2 == 0);
      run(1);
    end
    raw_in[1] = 1'b0; run(22);
    check("t2_no_pulse", npulse(1, 1, 30), 0);
    check("t2_no_level", level_h[12][1], 1'b0);

    // Channel returned to IDLE: a clean press is accepted again.
    mark(); raw_in[1] = 1'b1; run(12); raw_in[1] = 1'b0; run(23);
    check("t2_reaccept", pulse_h[10], 4'b0010);

    // Exactly THRESH hits accepted, THRESH-1 rejected (ch3).
    mark();
    for (int k = 0; k < 8; k++) begin
      raw_in[3] = (k < 6);
      run(1);
    end
    raw_in[3] = 1'b0; run(22);
    check("thresh_eq", pulse_h[10], 4'b1000);
    mark();
    for (int k = 0; k < 8; k++) begin
      raw_in[3] = (k < 5);
      run(1);
    end
    raw_in[3] = 1'b0; run(12);
    check("thresh_below", npulse(3, 1, 20), 0);

    // Simultaneous presses on ch1 and ch3.
    mark(); raw_in[1] = 1'b1; raw_in[3] = 1'b1; run(12);
    raw_in[1] = 1'b0; raw_in[3] = 1'b0; run(23);
    check("t5_pulse",     pulse_h[10], 4'b1010);
    check("t5_any_pre",   any_h[9],    1'b0);
    check("t5_any",       any_h[10],   1'b1);
    check("t5_any_post",  any_h[11],   1'b0);
    check("t5_level",     level_h[11], 4'b1010);

    // ch0 active-low: low 8, high 4, low 8 -> second press lands in lockout.
    mark(); raw_in[0] = 1'b0; run(8); raw_in[0] = 1'b1; run(4);
    raw_in[0] = 1'b0; run(8); raw_in[0] = 1'b1; run(20);
    check("t3_pulse",     pulse_h[10], 4'b0001);
    check("t3_count",     npulse(0, 1, 40), 1);
    check("t3_level_on",  level_h[13][0], 1'b1);
    check("t3_level_off", level_h[14][0], 1'b0);
    check("t3_level_lk",  level_h[25][0], 1'b0);

    // ch2 auto-repeat, held long enough for four repeats.
    repeat_en[2] = 1'b1;
    mark(); raw_in[2] = 1'b1; run(42); raw_in[2] = 1'b0; run(20);
    check("t4_p0",        pulse_h[10][2], 1'b1);
    check("t4_p20",       pulse_h[30][2], 1'b1);
    check("t4_p25",       pulse_h[35][2], 1'b1);
    check("t4_p30",       pulse_h[40][2], 1'b1);
    check("t4_p35",       pulse_h[45][2], 1'b1);
    check("t4_count",     npulse(2, 1, 62), 5);
    check("t4_level_on",  level_h[47][2], 1'b1);
    check("t4_level_off", level_h[48][2], 1'b0);

    // Release falls on the same cycle as a repeat: no pulse.
    mark(); raw_in[2] = 1'b1; run(39); raw_in[2] = 1'b0; run(25);
    check("rel_win_pulse", pulse_h[45][2], 1'b0);
    check("rel_win_count", npulse(2, 1, 64), 4);
    check("rel_win_lvl_a", level_h[44][2], 1'b1);
    check("rel_win_lvl_b", level_h[45][2], 1'b0);
    repeat_en[2] = 1'b0;

    // Reset during SAMPLE.
    mark(); raw_in[1] = 1'b1; run(5);
    resetN = 1'b0; #1;
    check("t6_samp_pulse", press_pulse, 4'b0000);
    check("t6_samp_level", press_level, 4'b0000);
    raw_in[1] = 1'b0; run(2); resetN = 1'b1; run(3);

    // Reset while the pulse is showing in HELD.
    mark(); raw_in[1] = 1'b1; run(10);
    check("t6_pre_pulse", pulse_h[10], 4'b0010);
    resetN = 1'b0; #1;
    check("t6_held_pulse", press_pulse, 4'b0000);
    check("t6_held_level", press_level, 4'b0000);
    check("t6_held_any",   any_press,   1'b0);
    raw_in[1] = 1'b0; run(2); resetN = 1'b1; run(2);

    // Clean press after reset.
    mark(); raw_in[1] = 1'b1; run(12); raw_in[1] = 1'b0; run(20);
    check("t6_after_pulse", pulse_h[10], 4'b0010);
    check("t6_after_count", npulse(1, 1, 32), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
